// File: rtl/trigger_monitor.sv
// Receive-side checker for a periodic trigger pulse: measures the interval,
// locks after LOCK_COUNT good periods and issues a one-cycle nul on loss of sync.
module trigger_monitor #(
  parameter int N          = 2,
  parameter int LOCK_COUNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       trigger,
  output logic       nul,
  output logic       locked,
  output logic       err,
  output logic [7:0] period,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2,
    RESYNC = 2'd3
  } state_t;

  localparam logic [7:0] N_L    = 8'(N);
  localparam logic [7:0] N_M1   = 8'(N - 1);
  localparam logic [3:0] LOCK_L = 4'(LOCK_COUNT);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t     state;
  logic [7:0] cnt;
  logic [3:0] good;
  logic [7:0] meas;
  logic [3:0] good_inc;
  logic       period_ok;
  logic       early;
  logic       timeout;
  logic       cnt_sat;

  // Interval closed by the current trigger (cnt counts cycles since the last one)
  assign meas      = sat_inc8(cnt);
  assign good_inc  = good + 4'd1;
  assign period_ok = (meas == N_L);
  assign early     = (meas < N_L);
  assign timeout   = (cnt == N_M1) && !trigger;
  assign cnt_sat   = (cnt == 8'hFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      good    <= 4'd0;
      period  <= 8'd0;
      err_cnt <= 8'd0;
      nul     <= 1'b0;
      err     <= 1'b0;
      locked  <= 1'b0;
    end else begin
      nul <= 1'b0;
      err <= 1'b0;
      cnt <= trigger ? 8'd0 : sat_inc8(cnt);

      if (!enable) begin
        // Disabling abandons any pending error without flagging it
        state  <= IDLE;
        good   <= 4'd0;
        locked <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            good   <= 4'd0;
            locked <= 1'b0;
            if (trigger) state <= HUNT;
          end

          HUNT: begin
            if (trigger) begin
              period <= meas;
              if (period_ok) begin
                good <= good_inc;
                if (good_inc == LOCK_L) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end else begin
                good <= 4'd0;
              end
            end else if (cnt_sat) begin
              state <= IDLE;
              good  <= 4'd0;
            end
          end

          LOCKED: begin
            if (trigger) period <= meas;
            if ((trigger && early) || timeout) begin
              state   <= RESYNC;
              nul     <= 1'b1;
              err     <= 1'b1;
              locked  <= 1'b0;
              err_cnt <= sat_inc8(err_cnt);
            end
          end

          RESYNC: begin
            // Trigger is ignored here; the generator is being restarted
            state  <= IDLE;
            cnt    <= 8'd0;
            good   <= 4'd0;
            locked <= 1'b0;
          end

          default: begin
            state  <= IDLE;
            good   <= 4'd0;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trigger_monitor.sv
// Directed bench for trigger_monitor: an N=4/LOCK_COUNT=3 instance for the main
// scenarios and an N=1/LOCK_COUNT=3 instance for the continuous-trigger and saturation cases.
module tb_trigger_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, trg, en1, trg1;
  logic       nul, locked, err, nul1, locked1, err1;
  logic [7:0] period, err_cnt, period1, err_cnt1;

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  trigger_monitor #(.N(4), .LOCK_COUNT(3)) dut (
    .clk(clk), .rst(rst), .enable(en), .trigger(trg),
    .nul(nul), .locked(locked), .err(err), .period(period), .err_cnt(err_cnt)
  );

  trigger_monitor #(.N(1), .LOCK_COUNT(3)) dut1 (
    .clk(clk), .rst(rst), .enable(en1), .trigger(trg1),
    .nul(nul1), .locked(locked1), .err(err1), .period(period1), .err_cnt(err_cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    trg = 1'b0;
    repeat (n) tick();
  endtask

  task automatic pulse();
    trg = 1'b1;
    tick();
    trg = 1'b0;
  endtask

  task automatic chk_all0(input string tag);
    chk({tag, "_nul"}, nul, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_errcnt"}, err_cnt, 0);
  endtask

  // From IDLE: entry trigger plus three period-4 intervals
  task automatic acquire(input string tag);
    gap(1);
    pulse();
    chk({tag, "_entry_locked"}, locked, 0);
    for (int i = 0; i < 3; i++) begin
      gap(3);
      pulse();
      chk({tag, "_period"}, period, 4);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_locked"}, locked, (i == 2) ? 1 : 0);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; trg = 1'b1; en1 = 1'b0; trg1 = 1'b0;

    // Reset with triggers toggling
    tick();
    chk_all0("rst_c1");
    trg = 1'b0;
    tick();
    chk_all0("rst_c2");
    rst = 1'b0;
    tick();
    chk_all0("rst_after");

    // Lock acquisition; the IDLE entry trigger must not latch period
    gap(3);
    pulse();
    chk("acq_entry_period", period, 0);
    chk("acq_entry_locked", locked, 0);
    for (int i = 0; i < 3; i++) begin
      gap(3);
      pulse();
      chk("acq_period", period, 4);
      chk("acq_err", err, 0);
      chk("acq_locked", locked, (i == 2) ? 1 : 0);
    end

    // Missing pulse
    gap(3);
    chk("miss_pre_locked", locked, 1);
    chk("miss_pre_err", err, 0);
    gap(1);
    chk("miss_err", err, 1);
    chk("miss_nul", nul, 1);
    chk("miss_locked", locked, 0);
    chk("miss_errcnt", err_cnt, 1);
    gap(1);
    chk("miss_err_off", err, 0);
    chk("miss_nul_off", nul, 0);
    gap(1);
    pulse();
    for (int i = 0; i < 3; i++) begin
      gap(3);
      pulse();
      chk("relock_locked", locked, (i == 2) ? 1 : 0);
      chk("relock_err", err, 0);
    end

    // Early pulse while locked
    gap(1);
    pulse();
    chk("early_period", period, 2);
    chk("early_err", err, 1);
    chk("early_nul", nul, 1);
    chk("early_locked", locked, 0);
    chk("early_errcnt", err_cnt, 2);
    gap(1);
    chk("early_nul_off", nul, 0);
    chk("early_err_off", err, 0);

    // HUNT with periods 4,5,4,4,4
    pulse();
    gap(3); pulse();
    chk("hunt_p4a_period", period, 4);
    chk("hunt_p4a_locked", locked, 0);
    gap(4); pulse();
    chk("hunt_p5_period", period, 5);
    chk("hunt_p5_err", err, 0);
    chk("hunt_p5_locked", locked, 0);
    gap(3); pulse();
    chk("hunt_p4b_locked", locked, 0);
    gap(3); pulse();
    chk("hunt_p4c_locked", locked, 0);
    chk("hunt_p4c_err", err, 0);
    gap(3); pulse();
    chk("hunt_p4d_locked", locked, 1);
    chk("hunt_errcnt", err_cnt, 2);

    // Enable drop while locked: no error even though a timeout would follow
    en = 1'b0;
    gap(1);
    chk("en_locked", locked, 0);
    chk("en_nul", nul, 0);
    gap(4);
    chk("en_late_nul", nul, 0);
    chk("en_late_err", err, 0);
    chk("en_errcnt", err_cnt, 2);
    en = 1'b1;

    // Reset during RESYNC
    acquire("rs");
    gap(4);
    chk("rs_nul", nul, 1);
    chk("rs_errcnt", err_cnt, 3);
    rst = 1'b1;
    tick();
    chk_all0("rs_inrst");
    rst = 1'b0;
    tick();
    chk_all0("rs_after");
    en = 1'b0;

    // N=1: continuous trigger locks after entry plus three periods
    en1 = 1'b1; trg1 = 1'b1;
    tick();
    chk("n1_entry_locked", locked1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("n1_period", period1, 1);
      chk("n1_locked", locked1, (i == 2) ? 1 : 0);
    end
    trg1 = 1'b0;
    tick();
    chk("n1_gap_err", err1, 1);
    chk("n1_gap_nul", nul1, 1);
    chk("n1_gap_locked", locked1, 0);
    chk("n1_errcnt", err_cnt1, 1);
    trg1 = 1'b1;
    tick();
    chk("n1_resync_err_off", err1, 0);
    chk("n1_resync_nul_off", nul1, 0);

    // Error count saturation: 255 further error events
    for (int i = 0; i < 255; i++) begin
      trg1 = 1'b1;
      repeat (4) tick();
      trg1 = 1'b0;
      tick();
      tick();
    end
    chk("sat_errcnt", err_cnt1, 255);
    trg1 = 1'b1;
    repeat (4) tick();
    chk("sat_locked", locked1, 1);
    trg1 = 1'b0;
    tick();
    chk("sat_err_pulse", err1, 1);
    chk("sat_errcnt_hold", err_cnt1, 255);
    tick();
    chk("sat_nul_off", nul1, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
